// File: rtl/audio_clkgen_nco_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_clkgen_pkg
// Purpose  : Shared types and constants for the audio NCO clock generator:
//            controller state encoding, default phase increments for common
//            audio clocks at 50 MHz / 32-bit accumulator, and a helper that
//            converts a target frequency into a phase increment.
// Revision : 1.0 - initial release
// ============================================================================
package audio_clkgen_pkg;

    // Controller states; explicit 2-bit encoding keeps the netlist stable.
    typedef enum logic [1:0] {
        FSM_SETTLE = 2'd0,
        FSM_LOCKED = 2'd1,
        FSM_UPDATE = 2'd2
    } fsm_e;

    // inc = round(hz * 2^acc_w / ref_hz); 64-bit intermediate avoids overflow
    // for any audio-range target with a 32-bit accumulator.
    function automatic logic [63:0] inc_from_hz(
        input logic [63:0] hz,
        input logic [63:0] ref_hz,
        input int          acc_w
    );
        return ((hz << acc_w) + (ref_hz >> 1)) / ref_hz;
    endfunction

    localparam logic [63:0] REF_HZ_50M = 64'd50000000;

    // Default increments at REF_HZ = 50 MHz, ACC_W = 32.
    localparam logic [31:0] INC_12M000  = 32'(inc_from_hz(64'd12000000, REF_HZ_50M, 32));
    localparam logic [31:0] INC_3M072   = 32'(inc_from_hz(64'd3072000,  REF_HZ_50M, 32));
    localparam logic [31:0] INC_48K000  = 32'(inc_from_hz(64'd48000,    REF_HZ_50M, 32));
    localparam logic [31:0] INC_44K100  = 32'(inc_from_hz(64'd44100,    REF_HZ_50M, 32));
    localparam logic [31:0] INC_11M2896 = 32'(inc_from_hz(64'd11289600, REF_HZ_50M, 32));

endpackage : audio_clkgen_pkg
`default_nettype wire

// File: rtl/audio_clkgen_nco_ch.sv
`default_nettype none
// ============================================================================
// Module   : audio_nco_ch
// Purpose  : One phase-accumulator NCO channel. The output clock is the
//            accumulator MSB straight from the register; the strobe is a
//            registered rising-edge detect aligned with the first high cycle.
//            A clear request zeroes the phase and strobe and optionally loads
//            a new increment in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module audio_nco_ch #(
    parameter int               ACC_W   = 32,
    parameter logic [ACC_W-1:0] INC_RST = {ACC_W{1'b0}}
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             outclk_o,
    output logic             outstb_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] inc_q;
    logic             outstb_q;
    logic             outstb_d;

    // Next phase (carry discarded) and rising-edge detect on the MSB.
    always_comb begin
        acc_d    = acc_q + inc_q;
        outstb_d = acc_d[ACC_W-1] & ~acc_q[ACC_W-1];
    end

    // Phase accumulator and strobe; a clear restarts the phase from zero.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            acc_q    <= {ACC_W{1'b0}};
            outstb_q <= 1'b0;
        end else if (clr_i) begin
            acc_q    <= {ACC_W{1'b0}};
            outstb_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            outstb_q <= outstb_d;
        end
    end

    // Increment register, written only by a load of this channel.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            inc_q <= INC_RST;
        end else if (load_i) begin
            inc_q <= inc_i;
        end
    end

    assign outclk_o = acc_q[ACC_W-1];
    assign outstb_o = outstb_q;

endmodule : audio_nco_ch
`default_nettype wire

// File: rtl/audio_clkgen_nco.sv
`default_nettype none
// ============================================================================
// Module   : audio_clkgen_nco
// Purpose  : Multi-channel runtime-reprogrammable audio clock generator.
//            NUM_CLKS NCO channels plus a SETTLE/LOCKED/UPDATE controller
//            that accepts one increment write at a time and re-runs the
//            settle interval after every write before reasserting locked.
//            rst is asynchronous active-low; its deassertion is expected to
//            be synchronised to refclk upstream.
// Options  : AUDIO_CLKGEN_SYNC_RESTART_EN - UPDATE clears every channel's
//            phase so all clocks restart aligned; otherwise only the
//            selected channel is restarted.
// Revision : 1.0 - initial release
// ============================================================================
module audio_clkgen_nco
    import audio_clkgen_pkg::*;
#(
    parameter int               NUM_CLKS    = 3,
    parameter int               ACC_W       = 32,
    parameter int unsigned      REF_HZ      = 50000000,
    parameter int               LOCK_CYCLES = 1024,
    parameter logic [ACC_W-1:0] INC_RST0    = ACC_W'(INC_12M000),
    parameter logic [ACC_W-1:0] INC_RST1    = ACC_W'(INC_3M072),
    parameter logic [ACC_W-1:0] INC_RST2    = ACC_W'(INC_48K000),
    localparam int              SEL_W       = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] outstb,
    output logic                locked
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    // Reject out-of-range configurations at elaboration.
    if (NUM_CLKS < 1 || NUM_CLKS > 8 || LOCK_CYCLES < 2 || REF_HZ == 0) begin : g_bad_param
        $error("audio_clkgen_nco: illegal parameter set");
    end

    fsm_e             state_q;
    fsm_e             state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic [ACC_W-1:0] wr_inc_q;
    logic [ACC_W-1:0] wr_inc_d;
    logic             upd;

    assign locked    = (state_q == FSM_LOCKED);
    assign cfg_ready = (state_q == FSM_LOCKED);
    assign upd       = (state_q == FSM_UPDATE);

    // Controller next state: settle count, handshake capture, one-cycle update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        wr_inc_d = wr_inc_q;
        case (state_q)
            FSM_SETTLE: begin
                if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = FSM_LOCKED;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FSM_LOCKED: begin
                if (cfg_valid) begin
                    sel_d    = cfg_sel;
                    wr_inc_d = cfg_inc;
                    state_d  = FSM_UPDATE;
                end
            end
            FSM_UPDATE: begin
                state_d = FSM_SETTLE;
                cnt_d   = {CNT_W{1'b0}};
            end
            default: begin
                state_d = FSM_SETTLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q  <= FSM_SETTLE;
            cnt_q    <= {CNT_W{1'b0}};
            sel_q    <= {SEL_W{1'b0}};
            wr_inc_q <= {ACC_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            wr_inc_q <= wr_inc_d;
        end
    end

    // One NCO per output; an out-of-range select matches no channel.
    for (genvar i = 0; i < NUM_CLKS; i++) begin : g_ch
        localparam logic [ACC_W-1:0] CH_INC_RST = (i == 0) ? INC_RST0 :
                                                  (i == 1) ? INC_RST1 :
                                                  (i == 2) ? INC_RST2 :
                                                             {ACC_W{1'b0}};
        logic hit;
        logic clr;

        assign hit = upd & (sel_q == SEL_W'(i));
`ifdef AUDIO_CLKGEN_SYNC_RESTART_EN
        assign clr = upd;
`else
        assign clr = hit;
`endif

        audio_nco_ch #(
            .ACC_W   (ACC_W),
            .INC_RST (CH_INC_RST)
        ) u_ch (
            .refclk   (refclk),
            .rst      (rst),
            .clr_i    (clr),
            .load_i   (hit),
            .inc_i    (wr_inc_q),
            .outclk_o (outclk[i]),
            .outstb_o (outstb[i])
        );
    end

endmodule : audio_clkgen_nco
`default_nettype wire

// File: tb/tb_audio_clkgen_nco.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_clkgen_nco
// Purpose  : Scoreboard bench for audio_clkgen_nco. The driver keeps a
//            closed-form model (phase = cycles since restart * inc, lock
//            time from handshake time) and queues the expected outputs of
//            every cycle; a monitor pops and compares on the falling edge.
//            Edge counts over windows are checked against f = REF*inc/2^32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_clkgen_nco;

    localparam int     NUM_CLKS    = 3;
    localparam int     ACC_W       = 32;
    localparam longint REF_HZ      = 50000000;
    localparam int     LOCK_CYCLES = 1024;
    localparam logic [31:0] DEF_INC [3] = '{32'd1030792151, 32'd263882791, 32'd4123169};

    logic        refclk    = 1'b0;
    logic        rst       = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_sel   = 2'd0;
    logic [31:0] cfg_inc   = 32'd0;
    wire         cfg_ready;
    wire         locked;
    wire  [2:0]  outclk;
    wire  [2:0]  outstb;

    audio_clkgen_nco u_dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_inc   (cfg_inc),
        .outclk    (outclk),
        .outstb    (outstb),
        .locked    (locked)
    );

    always #10 refclk = ~refclk;

    typedef struct {
        longint     n;
        logic [2:0] clk;
        logic [2:0] stb;
        logic       lck;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   stb_cnt [3] = '{0, 0, 0};

    // Reference model state (owned by the driver).
    longint      n;
    longint      base [3];
    logic [31:0] minc [3];
    longint      lock_edge;
    longint      upd_edge;
    logic [1:0]  pend_sel;
    logic [31:0] pend_inc;

    function automatic logic [31:0] acc_at(input int ch, input longint k);
        longint d;
        d = k - base[ch];
        if (d <= 0) return 32'd0;
        return 32'(d * longint'({32'd0, minc[ch]}));
    endfunction

    function automatic exp_t model_out(input longint k);
        exp_t e;
        e.n = k;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a_now;
            logic [31:0] a_prev;
            a_now    = acc_at(i, k);
            a_prev   = (k > 0) ? acc_at(i, k - 1) : 32'd0;
            e.clk[i] = a_now[31];
            e.stb[i] = (k > 0) ? (a_now[31] & ~a_prev[31]) : 1'b0;
        end
        e.lck = (k >= lock_edge);
        e.rdy = (k >= lock_edge);
        return e;
    endfunction

    task automatic model_reset();
        n         = 0;
        lock_edge = LOCK_CYCLES;
        upd_edge  = -1;
        for (int i = 0; i < 3; i++) begin
            base[i] = 0;
            minc[i] = DEF_INC[i];
        end
    endtask

    // Advance one refclk edge and queue the expected outputs after it.
    task automatic tick();
        @(posedge refclk);
        #1;
        n++;
        if (n == upd_edge) begin
`ifdef AUDIO_CLKGEN_SYNC_RESTART_EN
            for (int i = 0; i < 3; i++) base[i] = n;
`endif
            if (pend_sel < 2'(NUM_CLKS)) begin
                base[pend_sel] = n;
                minc[pend_sel] = pend_inc;
            end
        end
        exp_q.push_back(model_out(n));
    endtask

    // Present a write and hold it until the model says it is accepted.
    task automatic do_write(input logic [1:0] sel, input logic [31:0] inc);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_inc   = inc;
        while (n < lock_edge) tick();
        upd_edge  = n + 2;
        lock_edge = n + 2 + LOCK_CYCLES;
        pend_sel  = sel;
        pend_inc  = inc;
        tick();
        cfg_valid = 1'b0;
        cfg_sel   = 2'($urandom);
        cfg_inc   = $urandom;
    endtask

    // Release reset just after an edge so the next edge is cycle 1.
    task automatic release_reset();
        @(posedge refclk);
        @(posedge refclk);
        #1;
        rst = 1'b1;
        model_reset();
        exp_q.push_back(model_out(0));
    endtask

    // Count strobes over a window and compare with the nominal frequency.
    task automatic count_window(input int win, input longint hz0, input longint hz1,
                                input longint hz2);
        int     c0 [3];
        longint hz [3];
        longint diff;
        hz = '{hz0, hz1, hz2};
        for (int i = 0; i < 3; i++) c0[i] = stb_cnt[i];
        repeat (win) tick();
        @(negedge refclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            longint cnt;
            cnt  = longint'(stb_cnt[i] - c0[i]);
            diff = cnt * REF_HZ - longint'(win) * hz[i];
            vectors++;
            if (diff > REF_HZ || diff < -REF_HZ) begin
                miscompares++;
                $display("FAIL edge_count ch%0d: got %0d edges in %0d cycles, required %0d Hz +-1 edge",
                         i, cnt, win, hz[i]);
            end
        end
    endtask

    // Monitor: compare each queued expectation on the falling edge.
    initial begin : monitor
        exp_t e;
        logic prev_l;
        int   run;
        bit   in_run;
        prev_l = 1'b0;
        run    = 0;
        in_run = 1'b0;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({outclk, outstb, locked, cfg_ready} !== {e.clk, e.stb, e.lck, e.rdy}) begin
                    miscompares++;
                    $display("FAIL cycle %0d: got clk=%b stb=%b lck=%b rdy=%b, required clk=%b stb=%b lck=%b rdy=%b",
                             e.n, outclk, outstb, locked, cfg_ready, e.clk, e.stb, e.lck, e.rdy);
                end
            end
            for (int i = 0; i < 3; i++) if (outstb[i] === 1'b1) stb_cnt[i]++;
            if (!rst) begin
                in_run = 1'b0;
            end else begin
                if (prev_l && !locked) begin
                    in_run = 1'b1;
                    run    = 0;
                end
                if (in_run && !locked) run++;
                if (in_run && locked) begin
                    in_run = 1'b0;
                    vectors++;
                    if (run != LOCK_CYCLES + 1) begin
                        miscompares++;
                        $display("FAIL lock_low_len: got %0d cycles, required %0d", run, LOCK_CYCLES + 1);
                    end
                end
            end
            prev_l = locked;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Driver: stimulus sequence.
    initial begin : driver
        model_reset();
        release_reset();

        // Defaults: lock after LOCK_CYCLES, nominal 12 MHz / 3.072 MHz / 48 kHz.
        count_window(20000, 12000000, 3072000, 48000);

        // ch0 -> REF/4: pattern 0,0,1,1 with a strobe on each first 1.
        do_write(2'd0, 32'h4000_0000);
        repeat (300) tick();

        // Write issued during SETTLE stalls until the first LOCKED cycle.
        do_write(2'd1, 32'd0);
        while (n < lock_edge) tick();
        count_window(10000, 12500000, 0, 48000);

        // Out-of-range select: accepted, nothing changes, lock re-runs.
        do_write(2'd3, $urandom);
        while (n < lock_edge) tick();
        repeat (200) tick();

        // Reset mid-SETTLE after a write: async return to defaults.
        do_write(2'd0, $urandom_range(32'h0100_0000, 32'h7000_0000));
        repeat (300) tick();
        @(negedge refclk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if ({outclk, outstb, locked, cfg_ready} !== 8'b0) begin
            miscompares++;
            $display("FAIL async_reset: got clk=%b stb=%b lck=%b rdy=%b, required all 0",
                     outclk, outstb, locked, cfg_ready);
        end
        exp_q.delete();
        release_reset();
        repeat (3000) tick();

        // Randomised writes with random gaps.
        for (int w = 0; w < 5; w++) begin
            repeat ($urandom_range(0, 50)) tick();
            do_write(2'($urandom_range(0, 3)), $urandom);
            repeat ($urandom_range(20, 60)) tick();
        end
        while (n < lock_edge) tick();
        repeat (100) tick();

        @(negedge refclk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_audio_clkgen_nco
`default_nettype wire

// File: doc/audio_clkgen_nco.md
Name: audio_clkgen_nco

Overview:
- Multi-channel, runtime-reprogrammable audio clock generator in refclk logic, clocked by refclk (50 MHz).
- Each channel is a phase-accumulator NCO producing a 50%-duty-nominal clock (MCLK/BCLK/LRCLK class) plus a one-cycle rising-edge strobe.
- Adds per-channel frequency programming and a settle/lock indicator, with re-lock on every reconfiguration; the fixed single-output PLL wrapper has neither.
- Sits beside the audio PLL and feeds the codec serial interface and sample-rate logic.

Parameters:
- NUM_CLKS, 3, number of output channels (1..8).
- ACC_W, 32, accumulator width; f_out = REF_HZ*inc/2^ACC_W.
- REF_HZ, 50000000, refclk frequency; documentation and bench only.
- LOCK_CYCLES, 1024, settle cycles before locked asserts (>=2).
- INC_RST0, 1030792151, channel 0 reset increment (12.000 MHz).
- INC_RST1, 263882791, channel 1 reset increment (3.072 MHz).
- INC_RST2, 4123169, channel 2 reset increment (48 kHz).
- Channels >= 3 reset to increment 0.

Ports:
- refclk  in  1  reference clock; all logic is on its rising edge.
- rst  in  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronised to refclk.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  block can accept a write.
- cfg_sel  in  $clog2(NUM_CLKS) (min 1)  target channel.
- cfg_inc  in  ACC_W  new increment.
- outclk  out  NUM_CLKS  generated clocks, one per bit.
- outstb  out  NUM_CLKS  one-cycle pulse when the matching outclk rises.
- locked  out  1  all channels stable.

Behaviour:
- Reset values: every acc = 0, inc[i] = INC_RSTi, outclk = 0, outstb = 0, locked = 0, cfg_ready = 0, FSM = SETTLE, settle counter = 0.
- Per-channel datapath:
  - Each cycle: acc <= acc + inc, modulo 2^ACC_W, carry discarded.
  - outclk[i] = acc[ACC_W-1], taken directly from the register (glitch-free).
  - outstb[i] is registered: outstb[i] <= next_acc MSB & ~acc MSB. It is high in the first cycle outclk[i] reads 1.
  - inc = 0: acc is held at 0, outclk = 0, no strobes.
  - inc >= 2^(ACC_W-1) is legal. Output aliases, since it exceeds Nyquist. No checking is done.
- FSM states: SETTLE, LOCKED, UPDATE.
  - SETTLE: counter increments each cycle, locked = 0, cfg_ready = 0. When counter == LOCK_CYCLES-1, go to LOCKED and clear the counter.
  - LOCKED: locked = 1, cfg_ready = 1. cfg_valid & cfg_ready is a handshake: capture cfg_sel/cfg_inc and go to UPDATE.
  - UPDATE (exactly 1 cycle): inc[cfg_sel] <= captured value, acc[cfg_sel] <= 0, outstb[cfg_sel] <= 0. Then go to SETTLE. locked and cfg_ready are 0 in this cycle.
- Timing:
  - locked falls the cycle after the handshake.
  - locked rises LOCK_CYCLES+1 cycles after UPDATE.
- Boundary conditions:
  - cfg_sel >= NUM_CLKS: the handshake is accepted, no register changes, and the FSM still passes through UPDATE and SETTLE. This keeps software timing uniform.
  - cfg_valid in SETTLE/UPDATE: stalled (cfg_ready = 0). The requester holds its values until the handshake.
  - Unselected channels keep running untouched through UPDATE/SETTLE, unless the optional feature is enabled.
  - Reset mid-SETTLE or mid-UPDATE: immediate return to the reset values, including the increments; any pending write is lost.

Optional Feature:
- AUDIO_CLKGEN_SYNC_RESTART_EN defined: UPDATE clears every channel's acc and outstb in the same cycle. All clocks restart phase-aligned (common rising edge when the increments are rational multiples).
- Undefined: only the selected channel's acc is cleared.

Decomposition:
- Package audio_clkgen_pkg holds:
  - fsm enum (SETTLE, LOCKED, UPDATE);
  - default increment constants for 12 MHz, 3.072 MHz, 48 kHz, 44.1 kHz and 11.2896 MHz at REF_HZ = 50 MHz, ACC_W = 32;
  - a function computing inc from a target Hz.
- Sub-module audio_nco_ch holds one channel (acc, outclk, outstb, clear, inc register), instantiated NUM_CLKS times by generate. The top holds the FSM, counter and handshake.

Test Plan:
- Reset release with defaults: locked rises exactly LOCK_CYCLES cycles after deassertion. Over 10^6 cycles, ch0 shows 240000 ±1 rising edges, ch1 61440 ±1, ch2 960 ±1.
- Write ch0 inc = 0x4000_0000 (ACC_W = 32): after UPDATE, outclk0 repeats 0,0,1,1. outstb0 pulses every 4th cycle, coincident with each first 1. locked drops the next cycle and re-rises after LOCK_CYCLES+1.
- cfg_valid held during SETTLE: cfg_ready = 0 and no register change. The handshake completes on the first LOCKED cycle.
- Write inc = 0 to ch1: outclk1 stays 0, with no outstb1 pulses, for 10^4 cycles. ch0/ch2 edge counts are unaffected (feature off).
- cfg_sel = 3 with NUM_CLKS = 3: no inc change, and locked still drops for LOCK_CYCLES+1 cycles.
- rst asserted mid-SETTLE after a write: outputs go to reset values asynchronously, and ch0 resumes at the 12 MHz default. With AUDIO_CLKGEN_SYNC_RESTART_EN, all acc values read 0 in the cycle after UPDATE.
